// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, encodings and lane helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB,
        S_ERR
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_FUNCT3   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    function automatic logic f3_legal(input logic [2:0] f3, input logic st);
        if (st)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicating the datum across lanes lets the byte enables alone pick the target bytes
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    return {4{d[7:0]}};
            F3_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - picks the addressed lane of a read word and sign/zero extends it
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[offset*8 +: 8];
        half_sel = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding memory stage; LSU_BUS_TIMEOUT_EN adds a bus watchdog
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     is_load,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [DATA_WIDTH-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]    store_data,
    input  logic [ADDRESS_WIDTH-1:0] rd,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_addr,
    output logic [3:0]               mem_be,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_gnt,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic                     rf_we,
    output logic [ADDRESS_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0]    rf_wdata,
    output logic                     store_done,
    output logic                     err,
    output logic [1:0]               err_cause,
    output logic                     busy
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    lsu_state_t state, next_state;

    logic [2:0]               funct3_q;
    logic [1:0]               off_q;
    logic [ADDRESS_WIDTH-1:0] rd_q;
    logic                     is_store_q;
    logic                     accept;
    logic                     set_cause;
    logic [1:0]               cause_d;
    logic                     store_gnt;
    logic                     load_rsp;
    logic [DATA_WIDTH-1:0]    load_data;

`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Any state change restarts the count, so REQ and WAIT each get a full window
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (next_state != state)
            tmo_cnt <= '0;
        else if (state == S_REQ || state == S_WAIT)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        set_cause  = 1'b0;
        cause_d    = ERR_MISALIGN;
        store_gnt  = 1'b0;
        load_rsp   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid && (is_load ^ is_store)) begin
                    accept = 1'b1;
                    if (!f3_legal(funct3, is_store)) begin
                        next_state = S_ERR;
                        set_cause  = 1'b1;
                        cause_d    = ERR_FUNCT3;
                    end else if (misaligned(funct3, addr[1:0])) begin
                        next_state = S_ERR;
                        set_cause  = 1'b1;
                        cause_d    = ERR_MISALIGN;
                    end else begin
                        next_state = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    store_gnt  = is_store_q;
                    next_state = is_store_q ? S_IDLE : S_WAIT;
                end
`ifdef LSU_BUS_TIMEOUT_EN
                else if (tmo_hit) begin
                    next_state = S_ERR;
                    set_cause  = 1'b1;
                    cause_d    = ERR_TIMEOUT;
                end
`endif
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    load_rsp   = 1'b1;
                    next_state = S_WB;
                end
`ifdef LSU_BUS_TIMEOUT_EN
                else if (tmo_hit) begin
                    next_state = S_ERR;
                    set_cause  = 1'b1;
                    cause_d    = ERR_TIMEOUT;
                end
`endif
            end
            S_WB:    next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    load_extend u_load_extend (
        .mem_rdata (mem_rdata),
        .offset    (off_q),
        .funct3    (funct3_q),
        .data      (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_q   <= '0;
            off_q      <= '0;
            rd_q       <= '0;
            is_store_q <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            store_done <= 1'b0;
            err_cause  <= '0;
            rf_addr    <= '0;
            rf_wdata   <= '0;
        end else begin
            store_done <= store_gnt;
            if (accept) begin
                funct3_q   <= funct3;
                off_q      <= addr[1:0];
                rd_q       <= rd;
                is_store_q <= is_store;
                mem_we     <= is_store;
                mem_addr   <= {addr[DATA_WIDTH-1:2], 2'b00};
                mem_be     <= is_store ? store_be(funct3, addr[1:0]) : 4'b1111;
                mem_wdata  <= is_store ? store_lanes(funct3, store_data) : '0;
            end
            if (set_cause)
                err_cause <= cause_d;
            if (load_rsp) begin
                rf_addr  <= rd_q;
                rf_wdata <= load_data;
            end
        end
    end

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign mem_req   = (state == S_REQ);
    assign err       = (state == S_ERR);
    assign rf_we     = (state == S_WB) && (rf_addr != '0);

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic [4:0]  rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        rf_we, store_done, err, busy;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [1:0]  err_cause;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .is_load(is_load), .is_store(is_store), .funct3(funct3), .addr(addr),
        .store_data(store_data), .rd(rd), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .store_done(store_done), .err(err), .err_cause(err_cause), .busy(busy)
    );

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        int n = size_of(f3);
        logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
        logic [31:0] v = (rdata >> (8 * off)) & mask;
        if (!f3[2] && n < 4 && v[8 * n - 1])
            v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [1:0] off);
        int n = size_of(f3);
        return 4'(((1 << n) - 1) << off);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (size_of(f3) == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (size_of(f3) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    task automatic idle_inputs();
        req_valid = 0; is_load = 0; is_store = 0; funct3 = 0; addr = 0;
        store_data = 0; rd = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({rf_we, rf_addr, rf_wdata, store_done, err, err_cause, mem_req, mem_we,
             mem_be, mem_addr, mem_wdata, busy} !== '0 || req_ready !== 1'b1)
            begin errors++; $display("FAIL reset: outputs not cleared rf_wdata=%h mem_addr=%h busy=%b req_ready=%b",
                                     rf_wdata, mem_addr, busy, req_ready); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] r, input logic [31:0] rdata, input int gd, input int rvd);
        logic [31:0] exp = exp_load(f3, a[1:0], rdata);
        @(negedge clk);
        req_valid = 1; is_load = 1; funct3 = f3; addr = a; rd = r;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b want 1", name, req_ready); end
        @(negedge clk);
        req_valid = 0; is_load = 0; addr = $urandom;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== {a[31:2], 2'b00} || mem_be !== 4'hF)
            begin errors++; $display("FAIL %s bus: req=%b we=%b addr=%h be=%b want 1 0 %h 1111",
                                     name, mem_req, mem_we, mem_addr, mem_be, {a[31:2], 2'b00}); end
        for (int i = 0; i < gd; i++) begin
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== {a[31:2], 2'b00})
                begin errors++; $display("FAIL %s stall: req=%b addr=%h", name, mem_req, mem_addr); end
        end
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL %s wait: req=%b busy=%b want 0 1", name, mem_req, busy); end
        repeat (rvd) @(negedge clk);
        mem_rvalid = 1; mem_rdata = rdata;
        @(negedge clk);
        mem_rvalid = 0; mem_rdata = $urandom;
        checks++;
        if (rf_we !== (r != 0) || rf_addr !== r || rf_wdata !== exp)
            begin errors++; $display("FAIL %s wb: we=%b addr=%0d data=%h want %b %0d %h",
                                     name, rf_we, rf_addr, rf_wdata, (r != 0), r, exp); end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || busy !== 1'b0 || rf_wdata !== exp)
            begin errors++; $display("FAIL %s post: we=%b busy=%b data=%h want 0 0 %h",
                                     name, rf_we, busy, rf_wdata, exp); end
    endtask

    task automatic do_store(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input int gd);
        logic [3:0]  be = exp_be(f3, a[1:0]);
        logic [31:0] wd = exp_wdata(f3, d);
        @(negedge clk);
        req_valid = 1; is_store = 1; funct3 = f3; addr = a; store_data = d;
        @(negedge clk);
        req_valid = 0; is_store = 0; store_data = $urandom;
        for (int i = 0; i <= gd; i++) begin
            if (i == gd) mem_gnt = 1;
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== {a[31:2], 2'b00} ||
                mem_be !== be || mem_wdata !== wd)
                begin errors++; $display("FAIL %s bus[%0d]: req=%b we=%b addr=%h be=%b wdata=%h want be=%b wdata=%h",
                                         name, i, mem_req, mem_we, mem_addr, mem_be, mem_wdata, be, wd); end
            @(negedge clk);
        end
        mem_gnt = 0;
        checks++;
        if (store_done !== 1'b1 || busy !== 1'b0 || rf_we !== 1'b0 || mem_req !== 1'b0)
            begin errors++; $display("FAIL %s done: store_done=%b busy=%b rf_we=%b", name, store_done, busy, rf_we); end
        @(negedge clk);
        checks++;
        if (store_done !== 1'b0 || rf_we !== 1'b0)
            begin errors++; $display("FAIL %s pulse: store_done=%b rf_we=%b want 0 0", name, store_done, rf_we); end
    endtask

    task automatic do_err(input string name, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [1:0] cause);
        @(negedge clk);
        req_valid = 1; is_store = st; is_load = !st; funct3 = f3; addr = a;
        @(negedge clk);
        req_valid = 0; is_store = 0; is_load = 0;
        checks++;
        if (err !== 1'b1 || err_cause !== cause || mem_req !== 1'b0)
            begin errors++; $display("FAIL %s: err=%b cause=%b req=%b want 1 %b 0", name, err, err_cause, mem_req, cause); end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || req_ready !== 1'b1 || err_cause !== cause || mem_req !== 1'b0)
            begin errors++; $display("FAIL %s after: err=%b ready=%b cause=%b", name, err, req_ready, err_cause); end
    endtask

    task automatic test_directed();
        do_load("lw_zero_wait", 3'b010, 32'h100, 5'd5, 32'hDEAD_BEEF, 0, 0);
        checks++;
        if (rf_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_const: got %h want deadbeef", rf_wdata); end
        do_load("lb_sign", 3'b000, 32'h203, 5'd7, 32'h80FF_FF00, 1, 2);
        checks++;
        if (rf_wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_const: got %h want ffffff80", rf_wdata); end
        do_load("lbu_zero", 3'b100, 32'h203, 5'd7, 32'h80FF_FF00, 0, 1);
        checks++;
        if (rf_wdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_const: got %h want 00000080", rf_wdata); end
        do_store("sh_delayed", 3'b001, 32'h42, 32'h1234_ABCD, 3);
        do_load("lw_x0", 3'b010, 32'h8, 5'd0, 32'h1111_2222, 0, 0);
    endtask

    task automatic test_errors();
        do_err("misalign_lw", 1'b0, 3'b010, 32'h101, 2'b01);
        do_err("bad_f3_load", 1'b0, 3'b011, 32'h100, 2'b10);
        do_err("bad_f3_store", 1'b1, 3'b100, 32'h100, 2'b10);
        do_err("misalign_sh", 1'b1, 3'b001, 32'h43, 2'b01);
        @(negedge clk);
        req_valid = 1; is_load = 1; is_store = 1; funct3 = 3'b010; addr = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || err !== 1'b0)
            begin errors++; $display("FAIL both_ops: busy=%b req=%b err=%b want 0 0 0", busy, mem_req, err); end
        idle_inputs();
    endtask

    task automatic test_reset_in_flight();
        @(negedge clk);
        req_valid = 1; is_load = 1; funct3 = 3'b010; addr = 32'h40; rd = 5'd3;
        @(negedge clk);
        idle_inputs();
        #1 rst = 1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL rst_req: req=%b busy=%b want 0 0", mem_req, busy); end
        @(negedge clk);
        rst = 0;
        req_valid = 1; is_load = 1; funct3 = 3'b010; addr = 32'h40; rd = 5'd3;
        @(negedge clk);
        idle_inputs();
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        #1 rst = 1;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0)
            begin errors++; $display("FAIL rst_wait: busy=%b req=%b want 0 0", busy, mem_req); end
        @(negedge clk);
        rst = 0;
        mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_rvalid = 0;
        checks++;
        if (rf_we !== 1'b0 || busy !== 1'b0 || rf_wdata !== 32'h0)
            begin errors++; $display("FAIL late_rvalid: rf_we=%b busy=%b data=%h", rf_we, busy, rf_wdata); end
    endtask

    task automatic test_random();
        logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int k = 0; k < 30; k++) begin
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                logic [2:0] f3 = ld_f3[$urandom_range(0, 4)];
                a = a & ~32'(size_of(f3) - 1);
                do_load("rand_load", f3, a, 5'($urandom_range(0, 31)), $urandom,
                        $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                logic [2:0] f3 = 3'($urandom_range(0, 2));
                a = a & ~32'(size_of(f3) - 1);
                do_store("rand_store", f3, a, $urandom, $urandom_range(0, 3));
            end
        end
    endtask

`ifdef LSU_BUS_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        @(negedge clk);
        req_valid = 1; is_load = 1; funct3 = 3'b010; addr = 32'h80; rd = 5'd9;
        @(negedge clk);
        idle_inputs();
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        while (err !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 8 || err_cause !== 2'b11 || mem_req !== 1'b0)
            begin errors++; $display("FAIL timeout: cycles=%0d cause=%b want 8 11", n, err_cause); end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rf_we !== 1'b0)
            begin errors++; $display("FAIL timeout_idle: ready=%b rf_we=%b", req_ready, rf_we); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_reset_in_flight();
        test_random();
`ifdef LSU_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
